// File: rtl/idct_block_scheduler_if.sv
// Job handshake and RAM-ownership bundle between the IDCT block scheduler
// and the fetch/write and calc units.
interface idct_block_scheduler_if #(
  parameter int BLK_W = 12
);
  logic             start;
  logic             abort;
  logic             fs_done;
  logic             ct_done;
  logic             cs_done;
  logic             ws_done;
  logic             fs_en;
  logic             ct_en;
  logic             cs_en;
  logic             ws_en;
  logic [BLK_W-1:0] fs_blk;
  logic [BLK_W-1:0] ws_blk;
  logic             sprime_a_sel;
  logic             t_b_sel;
  logic             busy;
  logic             finish;
  logic             err;
  logic [1:0]       err_code;

  modport master (
    output start, abort, fs_done, ct_done, cs_done, ws_done,
    input  fs_en, ct_en, cs_en, ws_en, fs_blk, ws_blk,
           sprime_a_sel, t_b_sel, busy, finish, err, err_code
  );

  modport slave (
    input  start, abort, fs_done, ct_done, cs_done, ws_done,
    output fs_en, ct_en, cs_en, ws_en, fs_blk, ws_blk,
           sprime_a_sel, t_b_sel, busy, finish, err, err_code
  );
endinterface

// File: rtl/idct_block_scheduler.sv
// Schedules fetch S' / compute T / compute S / write S jobs for a frame of 8x8
// IDCT blocks and hands the S' and T RAM ports between the units.
//
// state     | meaning
// IDLE      | waiting for start
// FS0       | fetch S' of the first block (of every block in serial mode)
// CT        | compute T
// MS1       | compute S of block k while fetching S' of block k+1
// MS2       | write S of block k while computing T of block k+1
// CS_LAST   | compute S of the last block in flight
// WS_LAST   | write S of the last block in flight
// DONE      | one-cycle finish pulse
// ERR       | timeout or spurious done; waits for start
module idct_block_scheduler #(
  parameter int NUM_BLOCKS     = 2400,
  parameter int BLK_W          = 12,
  parameter int OVERLAP        = 1,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int TO_W           = 13
) (
  input logic                   CLOCK_50_I,
  input logic                   resetn,
  idct_block_scheduler_if.slave bus
);

  typedef enum logic [3:0] {
    S_IDLE, S_FS0, S_CT, S_MS1, S_MS2, S_CS_LAST, S_WS_LAST, S_DONE, S_ERR
  } state_t;

  localparam logic [BLK_W-1:0] NB      = BLK_W'(NUM_BLOCKS);
  localparam logic [BLK_W-1:0] NB_M1   = BLK_W'(NUM_BLOCKS - 1);
  localparam logic [TO_W-1:0]  TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic             WD_ON   = (TIMEOUT_CYCLES != 0);

  state_t           state, state_nxt, adv_state;
  logic             fs_f, ct_f, cs_f, ws_f;
  logic [TO_W-1:0]  wd_cnt;
  logic [BLK_W-1:0] fetched;
  logic             advance, start_acc;
  logic [1:0]       code_nxt;
  logic             working, all_ok, spurious, timeout;

  // A stage is satisfied if it is idle, already reported, or reporting now.
  assign all_ok = (!bus.fs_en || fs_f || bus.fs_done) && (!bus.ct_en || ct_f || bus.ct_done) &&
                  (!bus.cs_en || cs_f || bus.cs_done) && (!bus.ws_en || ws_f || bus.ws_done);
  assign working  = state inside {S_FS0, S_CT, S_MS1, S_MS2, S_CS_LAST, S_WS_LAST};
  assign spurious = working && ((bus.fs_done && !bus.fs_en) || (bus.ct_done && !bus.ct_en) ||
                                (bus.cs_done && !bus.cs_en) || (bus.ws_done && !bus.ws_en));
  assign timeout  = WD_ON && working && (wd_cnt == TO_LAST);

  always_ff @(posedge CLOCK_50_I or negedge resetn) begin
    if (!resetn) state <= S_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    adv_state = state;
    case (state)
      S_FS0:     adv_state = S_CT;
      S_CT:      adv_state = (OVERLAP != 0 && fetched < NB) ? S_MS1 : S_CS_LAST;
      S_MS1:     adv_state = S_MS2;
      S_MS2:     adv_state = (fetched < NB) ? S_MS1 : S_CS_LAST;
      S_CS_LAST: adv_state = S_WS_LAST;
      S_WS_LAST: adv_state = (OVERLAP == 0 && bus.ws_blk < NB_M1) ? S_FS0 : S_DONE;
      default:   adv_state = state;
    endcase

    state_nxt = state;
    advance   = 1'b0;
    start_acc = 1'b0;
    code_nxt  = 2'b00;
    if (bus.abort && state != S_IDLE) begin
      state_nxt = S_IDLE;
    end else if (state == S_IDLE || state == S_ERR) begin
      if (bus.start) begin
        state_nxt = S_FS0;
        start_acc = 1'b1;
      end
    end else if (state == S_DONE) begin
      state_nxt = S_IDLE;
    end else if (timeout && !(all_ok && !spurious)) begin
      state_nxt = S_ERR;
      code_nxt  = 2'b01;
    end else if (spurious) begin
      state_nxt = S_ERR;
      code_nxt  = 2'b10;
    end else if (all_ok) begin
      state_nxt = adv_state;
      advance   = 1'b1;
    end
  end

  // Any state change starts a fresh phase: done flags and watchdog clear.
  always_ff @(posedge CLOCK_50_I or negedge resetn) begin
    if (!resetn) begin
      {fs_f, ct_f, cs_f, ws_f} <= 4'b0000;
      wd_cnt                   <= '0;
    end else if (state_nxt != state) begin
      {fs_f, ct_f, cs_f, ws_f} <= 4'b0000;
      wd_cnt                   <= '0;
    end else begin
      fs_f   <= fs_f | (bus.fs_done & bus.fs_en);
      ct_f   <= ct_f | (bus.ct_done & bus.ct_en);
      cs_f   <= cs_f | (bus.cs_done & bus.cs_en);
      ws_f   <= ws_f | (bus.ws_done & bus.ws_en);
      wd_cnt <= (working && WD_ON) ? wd_cnt + 1'b1 : '0;
    end
  end

  always_ff @(posedge CLOCK_50_I or negedge resetn) begin
    if (!resetn) begin
      bus.fs_en        <= 1'b0;
      bus.ct_en        <= 1'b0;
      bus.cs_en        <= 1'b0;
      bus.ws_en        <= 1'b0;
      bus.sprime_a_sel <= 1'b0;
      bus.t_b_sel      <= 1'b0;
      bus.busy         <= 1'b0;
      bus.finish       <= 1'b0;
      bus.err          <= 1'b0;
      bus.err_code     <= 2'b00;
      bus.fs_blk       <= '0;
      bus.ws_blk       <= '0;
      fetched          <= '0;
    end else begin
      bus.fs_en        <= state_nxt inside {S_FS0, S_MS1};
      bus.ct_en        <= state_nxt inside {S_CT, S_MS2};
      bus.cs_en        <= state_nxt inside {S_MS1, S_CS_LAST};
      bus.ws_en        <= state_nxt inside {S_MS2, S_WS_LAST};
      bus.sprime_a_sel <= state_nxt inside {S_FS0, S_MS1};
      bus.t_b_sel      <= state_nxt inside {S_MS2, S_WS_LAST};
      bus.busy         <= !(state_nxt inside {S_IDLE, S_ERR});
      bus.finish       <= (state_nxt == S_DONE);

      if (start_acc) begin
        bus.err      <= 1'b0;
        bus.err_code <= 2'b00;
      end else if (state_nxt == S_ERR && state != S_ERR) begin
        bus.err      <= 1'b1;
        bus.err_code <= code_nxt;
      end

      if (start_acc) begin
        fetched    <= '0;
        bus.fs_blk <= '0;
        bus.ws_blk <= '0;
      end else if (advance) begin
        case (state)
          S_FS0: fetched <= BLK_W'(1);
          S_MS1: begin
            fetched    <= fetched + 1'b1;
            bus.fs_blk <= bus.fs_blk + 1'b1;
          end
          S_MS2: bus.ws_blk <= bus.ws_blk + 1'b1;
          S_WS_LAST: begin
            if (state_nxt == S_FS0) begin
              bus.fs_blk <= bus.fs_blk + 1'b1;
              bus.ws_blk <= bus.ws_blk + 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_idct_block_scheduler.sv
// Directed + randomized bench for idct_block_scheduler: three instances
// (overlapped N=3, serial N=2, overlapped N=1) checked against a phase model.
module tb_idct_block_scheduler;

  localparam int BW = 12;
  localparam int NI = 3;
  localparam int SW = 11 + 2 * BW;

  localparam int PH_IDLE = 0, PH_FS0 = 1, PH_CT = 2, PH_MS1 = 3, PH_MS2 = 4;
  localparam int PH_CSL = 5, PH_WSL = 6, PH_DONE = 7, PH_ERR = 8, PH_BAD = 9;

  typedef struct {
    int ph; int len; int fsb; int wsb;
    logic sa; logic tb; logic busy; logic err;
  } rec_t;

  logic       clk = 1'b0;
  logic       resetn;
  logic       start_r  [NI];
  logic       abort_r  [NI];
  logic [3:0] man_done [NI];
  int         dly_cfg  [NI][4];

  int   checks = 0;
  int   errors = 0;
  rec_t act_q[$];
  rec_t exp_q[$];

  always #10 clk = ~clk;

  idct_block_scheduler_if #(.BLK_W(BW)) bus [NI] ();

  for (genvar g = 0; g < NI; g++) begin : g_u
    localparam int NBG = (g == 0) ? 3 : ((g == 1) ? 2 : 1);
    localparam int OVG = (g == 1) ? 0 : 1;
    localparam int TOG = (g == 2) ? 0 : 16;

    idct_block_scheduler #(
      .NUM_BLOCKS(NBG), .BLK_W(BW), .OVERLAP(OVG), .TIMEOUT_CYCLES(TOG), .TO_W(13)
    ) dut (
      .CLOCK_50_I(clk),
      .resetn    (resetn),
      .bus       (bus[g])
    );

    logic [3:0]    en_v;
    logic [3:0]    ad = 4'b0000;
    logic [SW-1:0] sv;
    int            cnt    [4];
    logic          prev   [4];
    logic          served [4];

    assign en_v = {bus[g].ws_en, bus[g].cs_en, bus[g].ct_en, bus[g].fs_en};
    assign bus[g].start   = start_r[g];
    assign bus[g].abort   = abort_r[g];
    assign bus[g].fs_done = ad[0] | man_done[g][0];
    assign bus[g].ct_done = ad[1] | man_done[g][1];
    assign bus[g].cs_done = ad[2] | man_done[g][2];
    assign bus[g].ws_done = ad[3] | man_done[g][3];
    assign sv = {bus[g].fs_en, bus[g].ct_en, bus[g].cs_en, bus[g].ws_en,
                 bus[g].sprime_a_sel, bus[g].t_b_sel, bus[g].busy, bus[g].finish,
                 bus[g].err, bus[g].err_code, bus[g].fs_blk, bus[g].ws_blk};

    // Unit model: each job reports done dly_cfg cycles after its enable rises.
    always @(negedge clk) begin
      for (int s = 0; s < 4; s++) begin
        ad[s] = 1'b0;
        if (en_v[s] && !prev[s]) begin
          cnt[s]    = dly_cfg[g][s];
          served[s] = 1'b0;
        end
        if (en_v[s] && !served[s]) begin
          if (cnt[s] <= 1) begin
            ad[s]     = 1'b1;
            served[s] = 1'b1;
          end else begin
            cnt[s] = cnt[s] - 1;
          end
        end
        prev[s] = en_v[s];
      end
    end
  end

  function automatic logic [SW-1:0] snapv(int g);
    case (g)
      0:       return g_u[0].sv;
      1:       return g_u[1].sv;
      default: return g_u[2].sv;
    endcase
  endfunction

  function automatic int phase_of(logic [SW-1:0] v);
    logic [3:0] en;
    en = v[SW-1 -: 4];
    if (v[27]) return PH_DONE;
    case (en)
      4'b1000: return PH_FS0;
      4'b0100: return PH_CT;
      4'b1010: return PH_MS1;
      4'b0101: return PH_MS2;
      4'b0010: return PH_CSL;
      4'b0001: return PH_WSL;
      4'b0000: return v[28] ? PH_BAD : (v[26] ? PH_ERR : PH_IDLE);
      default: return PH_BAD;
    endcase
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  function automatic int max2(int a, int b);
    return (a > b) ? a : b;
  endfunction

  task automatic push_exp(int ph, int len, int fsb, int wsb);
    rec_t r;
    r.ph = ph; r.len = len; r.fsb = fsb; r.wsb = wsb;
    r.sa   = (ph == PH_FS0 || ph == PH_MS1);
    r.tb   = (ph == PH_MS2 || ph == PH_WSL);
    r.busy = (ph != PH_ERR && ph != PH_IDLE);
    r.err  = (ph == PH_ERR);
    exp_q.push_back(r);
  endtask

  // Expected phase list for a clean frame, with phase length = slowest active job.
  task automatic build_exp(int n, int ov, int dfs, int dct, int dcs, int dws);
    exp_q.delete();
    if (ov != 0) begin
      push_exp(PH_FS0, dfs, 0, 0);
      push_exp(PH_CT, dct, 0, 0);
      for (int k = 1; k < n; k++) begin
        push_exp(PH_MS1, max2(dcs, dfs), k - 1, k - 1);
        push_exp(PH_MS2, max2(dws, dct), k, k - 1);
      end
      push_exp(PH_CSL, dcs, n - 1, n - 1);
      push_exp(PH_WSL, dws, n - 1, n - 1);
    end else begin
      for (int b = 0; b < n; b++) begin
        push_exp(PH_FS0, dfs, b, b);
        push_exp(PH_CT, dct, b, b);
        push_exp(PH_CSL, dcs, b, b);
        push_exp(PH_WSL, dws, b, b);
      end
    end
    push_exp(PH_DONE, 1, n - 1, n - 1);
  endtask

  task automatic capture(int g, int budget, string tag);
    rec_t          r;
    logic [SW-1:0] v;
    int            ph;
    int            tmo;
    act_q.delete();
    tmo = 1;
    for (int c = 0; c < budget; c++) begin
      v  = snapv(g);
      ph = phase_of(v);
      if (act_q.size() > 0 && act_q[act_q.size()-1].ph == ph) begin
        r = act_q[act_q.size()-1];
        r.len++;
        act_q[act_q.size()-1] = r;
      end else begin
        r.ph = ph; r.len = 1; r.fsb = int'(v[23:12]); r.wsb = int'(v[11:0]);
        r.sa = v[30]; r.tb = v[29]; r.busy = v[28]; r.err = v[26];
        act_q.push_back(r);
      end
      if (ph == PH_DONE || ph == PH_ERR || ph == PH_IDLE || ph == PH_BAD) begin
        tmo = 0;
        break;
      end
      @(negedge clk);
    end
    chk({tag, "_budget"}, tmo, 0);
  endtask

  task automatic compare_q(string tag);
    int n;
    chk({tag, "_nphases"}, act_q.size(), exp_q.size());
    n = (act_q.size() < exp_q.size()) ? act_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s_p%0d_phase", tag, i), act_q[i].ph,   exp_q[i].ph);
      chk($sformatf("%s_p%0d_len",   tag, i), act_q[i].len,  exp_q[i].len);
      chk($sformatf("%s_p%0d_fsblk", tag, i), act_q[i].fsb,  exp_q[i].fsb);
      chk($sformatf("%s_p%0d_wsblk", tag, i), act_q[i].wsb,  exp_q[i].wsb);
      chk($sformatf("%s_p%0d_sasel", tag, i), act_q[i].sa,   exp_q[i].sa);
      chk($sformatf("%s_p%0d_tbsel", tag, i), act_q[i].tb,   exp_q[i].tb);
      chk($sformatf("%s_p%0d_busy",  tag, i), act_q[i].busy, exp_q[i].busy);
      chk($sformatf("%s_p%0d_err",   tag, i), act_q[i].err,  exp_q[i].err);
    end
  endtask

  task automatic set_dly(int g, int dfs, int dct, int dcs, int dws);
    dly_cfg[g][0] = dfs; dly_cfg[g][1] = dct; dly_cfg[g][2] = dcs; dly_cfg[g][3] = dws;
  endtask

  task automatic pulse_start(int g);
    start_r[g] = 1'b1;
    @(negedge clk);
    start_r[g] = 1'b0;
  endtask

  task automatic run_frame(int g, int n, int ov, int dfs, int dct, int dcs, int dws, string tag);
    logic [SW-1:0] v;
    set_dly(g, dfs, dct, dcs, dws);
    build_exp(n, ov, dfs, dct, dcs, dws);
    pulse_start(g);
    capture(g, 400, tag);
    compare_q(tag);
    @(negedge clk);
    v = snapv(g);
    chk({tag, "_after_busy"},   v[28], 0);
    chk({tag, "_after_finish"}, v[27], 0);
    chk({tag, "_after_phase"},  phase_of(v), PH_IDLE);
  endtask

  initial begin
    logic [SW-1:0] v;
    int            found;
    int            fin_cnt;
    int            d[4];

    resetn = 1'b0;
    for (int g = 0; g < NI; g++) begin
      start_r[g] = 1'b0; abort_r[g] = 1'b0; man_done[g] = 4'b0000;
      set_dly(g, 5, 5, 5, 5);
    end
    repeat (3) @(negedge clk);
    for (int g = 0; g < NI; g++) chk($sformatf("reset_vec_u%0d", g), snapv(g), 0);
    resetn = 1'b1;
    @(negedge clk);

    run_frame(0, 3, 1, 5, 5, 5, 5, "ovl3_d5");
    run_frame(1, 2, 0, 5, 5, 5, 5, "ser2_d5");
    run_frame(2, 1, 1, 5, 5, 5, 5, "ovl1_d5");
    run_frame(0, 3, 1, 9, 5, 3, 5, "ovl3_cs3_fs9");

    // Watchdog: CT never reports done.
    set_dly(0, 4, 255, 5, 5);
    exp_q.delete();
    push_exp(PH_FS0, 4, 0, 0);
    push_exp(PH_CT, 16, 0, 0);
    push_exp(PH_ERR, 1, 0, 0);
    pulse_start(0);
    capture(0, 100, "timeout");
    compare_q("timeout");
    v = snapv(0);
    chk("timeout_code", v[25:24], 2'b01);
    chk("timeout_en",   v[SW-1 -: 4], 4'b0000);
    run_frame(0, 3, 1, 5, 5, 5, 5, "restart_after_err");

    // Spurious ws_done while fetching block 0.
    set_dly(0, 6, 5, 5, 5);
    pulse_start(0);
    v = snapv(0);
    chk("spur_pre_phase", phase_of(v), PH_FS0);
    man_done[0] = 4'b1000;
    @(negedge clk);
    man_done[0] = 4'b0000;
    v = snapv(0);
    chk("spur_phase", phase_of(v), PH_ERR);
    chk("spur_err",   v[26], 1);
    chk("spur_code",  v[25:24], 2'b10);

    // Abort during MS2.
    set_dly(0, 3, 3, 3, 3);
    pulse_start(0);
    found = 0;
    for (int c = 0; c < 100 && found == 0; c++) begin
      if (phase_of(snapv(0)) == PH_MS2) found = 1;
      else @(negedge clk);
    end
    chk("abort_reach_ms2", found, 1);
    abort_r[0] = 1'b1;
    @(negedge clk);
    abort_r[0] = 1'b0;
    v = snapv(0);
    chk("abort_phase", phase_of(v), PH_IDLE);
    chk("abort_busy",  v[28], 0);
    chk("abort_err",   v[26], 0);
    fin_cnt = int'(v[27]);
    repeat (10) begin
      @(negedge clk);
      fin_cnt += int'(snapv(0)) >> 27 & 1;
    end
    chk("abort_no_finish", fin_cnt, 0);

    // Randomized job latencies on every configuration.
    for (int rep = 0; rep < 3; rep++) begin
      for (int g = 0; g < NI; g++) begin
        for (int s = 0; s < 4; s++) d[s] = int'($urandom_range(1, 7));
        run_frame(g, (g == 0) ? 3 : ((g == 1) ? 2 : 1), (g == 1) ? 0 : 1,
                  d[0], d[1], d[2], d[3], $sformatf("rnd%0d_u%0d", rep, g));
      end
    end

    // Asynchronous reset mid-frame.
    set_dly(0, 5, 5, 5, 5);
    pulse_start(0);
    repeat (7) @(negedge clk);
    #2 resetn = 1'b0;
    #1 chk("midframe_reset_vec", snapv(0), 0);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
